// File: rtl/ps2_kb_receiver.sv
// ps2_kb_receiver
//   PS/2 keyboard front end for the CPU keyboard input path. The raw kb clock
//   and data lines are synchronised, and the clock is deglitched. 11-bit frames
//   are deframed, and E0/F0 prefix bytes are folded into flags. Completed scan
//   codes are queued in a small show-ahead FIFO that the CPU pops with a
//   one-cycle read strobe.
//
// Ports
//   clk          system clock, all logic on posedge
//   rst          synchronous, active-low reset
//   ps2_clk      raw keyboard clock (asynchronous)
//   ps2_data     raw keyboard data (asynchronous)
//   rd_en        pop strobe, one entry per cycle high
//   scan_code    head-of-FIFO code byte (0 when empty)
//   is_break     head entry was preceded by F0
//   is_extended  head entry was preceded by E0
//   code_valid   FIFO non-empty
//   frame_err    one-cycle pulse on parity, stop or timeout error
//   overflow     sticky, a code was dropped because the FIFO was full
module ps2_kb_receiver #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic [7:0] scan_code,
  output logic       is_break,
  output logic       is_extended,
  output logic       code_valid,
  output logic       frame_err,
  output logic       overflow
);

  localparam int FCW = $clog2(FILTER_LEN) + 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  localparam logic [FCW-1:0] FCNT_MAX = FCW'(FILTER_LEN - 1);
  localparam logic [TW-1:0]  TO_MAX   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]  DEPTH    = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Synchronisers and clock filter. They are preset high, which is the idle
  // bus level, so that leaving reset never fakes a falling edge.
  logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic           filt_q, filt_prev_q;
  logic [FCW-1:0] fcnt_q;
  logic           fall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
    end else begin
      clk_s1_q    <= ps2_clk;
      clk_s2_q    <= clk_s1_q;
      dat_s1_q    <= ps2_data;
      dat_s2_q    <= dat_s1_q;
      filt_prev_q <= filt_q;
      // Count consecutive samples that disagree with the filtered level.
      // The filtered level flips on the FILTER_LEN-th disagreeing sample.
      if (clk_s2_q == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FCNT_MAX) begin
        filt_q <= clk_s2_q;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end
  end

  assign fall = filt_prev_q & ~filt_q;

  // Deframing FSM
  state_t        state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic          err_q, err_d;
  logic          push;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      to_cnt_q <= '0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      to_cnt_q <= to_cnt_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    to_cnt_d = to_cnt_q;
    ext_d    = ext_q;
    brk_d    = brk_q;
    err_d    = 1'b0;
    push     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fall && !dat_s2_q) begin
          state_d  = DATA;
          bitcnt_d = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d  = {dat_s2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_d   = dat_s2_q;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          // Stop bit must be high and data+parity must carry odd parity.
          if (dat_s2_q && (^{shift_q, par_q})) begin
            if (shift_q == 8'hE0) begin
              ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
              brk_d = 1'b1;
            end else begin
              push  = 1'b1;
              ext_d = 1'b0;
              brk_d = 1'b0;
            end
          end else begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The watchdog only runs mid-frame. Every falling edge restarts it.
    if (state_q == IDLE) begin
      to_cnt_d = '0;
    end else if (fall) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_MAX) begin
      state_d  = IDLE;
      err_d    = 1'b1;
      ext_d    = 1'b0;
      brk_d    = 1'b0;
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  // Show-ahead FIFO of {ext, brk, code}
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full, empty, pop, do_write;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH);
  assign pop      = rd_en & ~empty;
  // A full FIFO still accepts a write when the same cycle frees a slot.
  assign do_write = push & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (do_write) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)      rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_write && !pop)      count_d = count_q + 1'b1;
    else if (!do_write && pop) count_d = count_q - 1'b1;
    if (push && !do_write) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr_q] <= {ext_q, brk_q, shift_q};
  end

  assign code_valid = ~empty;
  assign {is_extended, is_break, scan_code} = code_valid ? mem[rd_ptr_q] : 10'd0;
  assign frame_err  = err_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_kb_receiver.sv
// tb_ps2_kb_receiver
//   Directed bench for ps2_kb_receiver. PS/2 frames are bit-banged at a
//   scaled-down rate of HALF clk cycles per clock phase. The bench uses a short
//   timeout so the abort path can be exercised quickly.
module tb_ps2_kb_receiver;

  localparam int HALF = 20;
  localparam int TO   = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] scan_code;
  logic       is_break, is_extended, code_valid, frame_err, overflow;

  int n_chk  = 0;
  int n_pass = 0;
  int err_cnt = 0;
  int err_base;

  ps2_kb_receiver #(
    .FILTER_LEN    (4),
    .TIMEOUT_CYCLES(TO),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rd_en      (rd_en),
    .scan_code  (scan_code),
    .is_break   (is_break),
    .is_extended(is_extended),
    .code_valid (code_valid),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Counts the cycles frame_err is high. Each error is one pulse of one cycle.
  always @(posedge clk) if (frame_err === 1'b1) err_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // bits[0] is the start bit. The first n bits are clocked out.
  task automatic send_raw(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      wait_clks(HALF);
      ps2_clk = 1'b0;
      wait_clks(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic par_flip, input logic stop);
    logic [10:0] bits;
    bits = {stop, (~^b) ^ par_flip, b, 1'b0};
    send_raw(bits, 11);
    ps2_data = 1'b1;
    wait_clks(2 * HALF);
    $display("frame byte=0x%02h par_flip=%0b stop=%0b", b, par_flip, stop);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    wait_clks(1);
    rd_en = 1'b0;
  endtask

  function automatic logic [31:0] head();
    return {22'd0, is_extended, is_break, scan_code};
  endfunction

  initial begin
    // Reset state
    wait_clks(5);
    check("rst_valid", code_valid, 0);
    check("rst_head", head(), 0);
    check("rst_err", frame_err, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b1;
    wait_clks(10);
    err_base = err_cnt;

    // 1: single code, then pop
    send_byte(8'h1C, 1'b0, 1'b1);
    check("t1_valid", code_valid, 1);
    check("t1_head", head(), {22'd0, 2'b00, 8'h1C});
    pop();
    check("t1_pop_valid", code_valid, 0);

    // 2: prefixes folded into flags
    send_byte(8'hF0, 1'b0, 1'b1);
    send_byte(8'h1C, 1'b0, 1'b1);
    send_byte(8'hE0, 1'b0, 1'b1);
    send_byte(8'hF0, 1'b0, 1'b1);
    send_byte(8'h75, 1'b0, 1'b1);
    check("t2_head0", head(), {22'd0, 2'b01, 8'h1C});
    pop();
    check("t2_head1", head(), {22'd0, 2'b11, 8'h75});
    pop();
    check("t2_empty", code_valid, 0);
    check("t2_no_err", err_cnt - err_base, 0);

    // 3: parity and stop errors, prefix flag cleared by the error
    err_base = err_cnt;
    send_byte(8'hF0, 1'b0, 1'b1);
    send_byte(8'h1C, 1'b1, 1'b1);
    send_byte(8'h1C, 1'b0, 1'b0);
    check("t3_err_pulses", err_cnt - err_base, 2);
    check("t3_valid", code_valid, 0);
    send_byte(8'h29, 1'b0, 1'b1);
    check("t3_head", head(), {22'd0, 2'b00, 8'h29});
    pop();

    // 4: overflow with depth 4
    send_byte(8'h16, 1'b0, 1'b1);
    send_byte(8'h1E, 1'b0, 1'b1);
    send_byte(8'h26, 1'b0, 1'b1);
    check("t4_no_ovf_yet", overflow, 0);
    send_byte(8'h25, 1'b0, 1'b1);
    send_byte(8'h2E, 1'b0, 1'b1);
    check("t4_ovf", overflow, 1);
    check("t4_pop0", head(), {22'd0, 2'b00, 8'h16});
    pop();
    check("t4_pop1", head(), {22'd0, 2'b00, 8'h1E});
    pop();
    check("t4_pop2", head(), {22'd0, 2'b00, 8'h26});
    pop();
    check("t4_pop3", head(), {22'd0, 2'b00, 8'h25});
    pop();
    check("t4_empty", code_valid, 0);
    check("t4_ovf_sticky", overflow, 1);

    // 5: timeout mid-frame (start + 4 data bits of 0x1C)
    err_base = err_cnt;
    send_raw({1'b1, 1'b0, 8'h1C, 1'b0}, 5);
    wait_clks(TO + 50);
    check("t5_timeout_err", err_cnt - err_base, 1);
    check("t5_valid", code_valid, 0);
    send_byte(8'h1C, 1'b0, 1'b1);
    check("t5_head", head(), {22'd0, 2'b00, 8'h1C});
    check("t5_err_total", err_cnt - err_base, 1);

    // 6: reset during data bit 5 with an entry queued, then clock glitches
    err_base = err_cnt;
    send_raw({1'b1, 1'b0, 8'h1C, 1'b0}, 6);
    ps2_data = 1'b0;
    wait_clks(5);
    rst = 1'b0;
    wait_clks(2);
    check("t6_rst_valid", code_valid, 0);
    check("t6_rst_head", head(), 0);
    check("t6_rst_ovf", overflow, 0);
    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      wait_clks(10);
      ps2_clk = 1'b0;
      wait_clks(3);
      ps2_clk = 1'b1;
    end
    wait_clks(TO + 50);
    ps2_data = 1'b1;
    wait_clks(10);
    check("t6_no_err", err_cnt - err_base, 0);
    check("t6_valid", code_valid, 0);
    send_byte(8'h1C, 1'b0, 1'b1);
    check("t6_head", head(), {22'd0, 2'b00, 8'h1C});
    check("t6_err_after", err_cnt - err_base, 0);
    pop();
    check("t6_empty", code_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ps2_kb_receiver.md
Name: ps2_kb_receiver

Overview:
PS/2 keyboard front end that feeds the CPU's keyboard input path. It synchronises and deglitches the raw kb clock and data lines, deframes 11-bit PS/2 frames, folds E0/F0 prefix bytes into flags, and queues completed scan codes in a small show-ahead FIFO. The CPU pops entries with a one-cycle read strobe. Runs on the CPU clock domain (slowClk or system clk).

Parameters:
FILTER_LEN, 4, consecutive equal synchronised ps2_clk samples required before the filtered clock changes.
TIMEOUT_CYCLES, 50000, clk cycles with no falling edge mid-frame before the frame is aborted.
FIFO_DEPTH, 4, entries; power of two, ≥2.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  reset, synchronous, active-low.
ps2_clk  in  1  raw keyboard clock, asynchronous.
ps2_data  in  1  raw keyboard data, asynchronous.
rd_en  in  1  pop strobe; one entry per cycle high.
scan_code  out  8  head-of-FIFO code byte.
is_break  out  1  head entry preceded by F0.
is_extended  out  1  head entry preceded by E0.
code_valid  out  1  FIFO non-empty.
frame_err  out  1  one-cycle pulse on parity, stop or timeout error.
overflow  out  1  sticky; set when a code is dropped because the FIFO is full.

Behaviour:
- Reset (rst=0 at posedge): FSM=IDLE, FIFO empty, prefix flags cleared, timeout counter 0. Synchronisers and filter are preset to 1. All outputs are 0.
- Synchronisation: ps2_clk and ps2_data each pass through a 2-flop synchroniser.
- Clock filter: the filtered clock takes the synchronised value after FILTER_LEN consecutive identical samples.
- Edge detection: a filtered 1→0 transition asserts fall for one cycle. Data is sampled from the synchronised ps2_data in the same cycle.
- FSM states:
  - IDLE: on fall with data=0 (start bit), go to DATA with bitcnt=0. On fall with data=1, stay in IDLE with no error.
  - DATA: on each fall, shift data in LSB first. After the 8th bit, go to PARITY.
  - PARITY: on fall, capture the parity bit and go to STOP.
  - STOP: on fall, check that data=1 and that the data bits plus parity have an odd number of ones. Either check failing → frame_err pulse, prefix flags cleared, byte discarded. Then go to IDLE.
- Byte handling on a good frame:
  - 0xE0: set ext flag, no push.
  - 0xF0: set brk flag, no push.
  - Any other byte: push {ext,brk,byte} and clear both flags.
- Latency: if fall of the stop bit is high in cycle N, the FIFO write happens at the end of N and code_valid/scan_code reflect it in N+1 (when the FIFO was empty). frame_err for a bad frame is high in cycle N+1 only.
- Timeout: in any non-IDLE state, the counter increments each cycle without fall and resets on fall.
  - When it reaches TIMEOUT_CYCLES-1, go to IDLE, pulse frame_err, clear prefix flags, counter to 0.
  - In IDLE the counter is held at 0.
- FIFO: show-ahead; outputs always show the head entry.
  - rd_en while empty: ignored.
  - Push while full without pop: entry dropped, overflow←1, FIFO contents unchanged.
  - Simultaneous push and pop while full: both occur, count unchanged, no overflow.
  - Simultaneous push and pop while empty: push occurs, pop ignored.
  - overflow clears only on reset.
- Reset mid-frame: partial frame discarded, no frame_err. Reception resumes with the next start bit after the filter settles.
- When code_valid=0, scan_code/is_break/is_extended are 0.

Test Plan:
1. Frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12.5 kHz → one cycle after the stop edge: code_valid=1, scan_code=0x1C, is_break=0, is_extended=0. Pulse rd_en → code_valid=0.
2. Frames F0,1C then E0,F0,75 → two entries: {0,1,0x1C} then {1,1,0x75}. Prefix bytes never appear on scan_code.
3. 0x1C sent with parity=1, then again with stop=0 → two frame_err pulses, code_valid stays 0, prefix flags cleared. A following good 0x29 yields scan_code=0x29.
4. Five codes 0x16,0x1E,0x26,0x25,0x2E with no rd_en → 4 entries, overflow=1, head=0x16. Pops return 0x16,0x1E,0x26,0x25, then code_valid=0.
5. Start bit plus 4 data bits, then ps2_clk held high for TIMEOUT_CYCLES → frame_err pulse, FSM=IDLE. The next full 0x1C frame is received correctly.
6. Assert rst=0 for 2 cycles during data bit 5 and inject 3-cycle glitches on ps2_clk → all outputs 0, no frame_err, glitches produce no edges. The subsequent 0x1C frame is received intact.
